// File: rtl/uart_frame_tx_pkg.sv
// Shared definitions for the PC-bound UART frame transmitter:
// frame width, default baud divider and FSM state encoding.
package uart_frame_tx_pkg;

  // Width of one PC-bound frame; always a whole number of bytes.
  localparam int SEND_TO_PC_SIZE  = 40;
  // 50 MHz system clock divided down to 115200 baud.
  localparam int BAUD_DIV_DEFAULT = 434;
  localparam int BITS_PER_BYTE    = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_STOP     = 3'd3,
    ST_DONE     = 3'd4,
    ST_WAIT_LOW = 3'd5
  } state_t;

endpackage

// File: rtl/uart_frame_tx_baud_tick.sv
// Baud-rate tick generator: counts 0..BAUD_DIV-1 while enabled and
// emits a one-cycle tick on the last count of each bit period.
module uart_baud_tick #(
  parameter int BAUD_DIV = 434,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Next count: clear wins, otherwise wrap at the end of each bit period.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // Counter register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = enable && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// UART 8N1 transmitter for whole frames: accepts a frame on a level-held
// send request, sends it most significant byte first, pulses send_done,
// then waits for send to drop before accepting another frame.
module uart_frame_tx
  import uart_frame_tx_pkg::*;
#(
  parameter int FRAME_BITS = SEND_TO_PC_SIZE,
  parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  send,
  input  logic [FRAME_BITS-1:0] data,
  output logic                  send_done,
  output logic                  tx,
  output logic                  busy
);

  localparam int NUM_BYTES = FRAME_BITS / BITS_PER_BYTE;
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  state_t                  state_reg, state_next;
  logic [FRAME_BITS-1:0]   frame_reg, frame_next;
  logic [BYTE_W-1:0]       byte_idx_reg, byte_idx_next;
  logic [2:0]              bit_idx_reg, bit_idx_next;
  logic [7:0]              cur_byte;
  logic                    accept;
  logic                    baud_en;
  logic                    tick;

  // The byte on the wire always sits at the top of the frame register,
  // because the register shifts left by one byte after every stop bit.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cur_byte
      assign cur_byte[gi] = frame_reg[FRAME_BITS-8+gi];
    end
  endgenerate

  assign accept  = (state_reg == ST_IDLE) && send;
  assign baud_en = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                   (state_reg == ST_STOP);

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_W    (CNT_W)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (baud_en),
    .tick   (tick)
  );

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      frame_reg    <= '0;
      byte_idx_reg <= '0;
      bit_idx_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      frame_reg    <= frame_next;
      byte_idx_reg <= byte_idx_next;
      bit_idx_reg  <= bit_idx_next;
    end
  end

  // Next-state and datapath update; bit boundaries come from the baud tick.
  always_comb begin
    state_next    = state_reg;
    frame_next    = frame_reg;
    byte_idx_next = byte_idx_reg;
    bit_idx_next  = bit_idx_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (send) begin
          frame_next    = data;
          byte_idx_next = '0;
          bit_idx_next  = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_reg == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (byte_idx_reg == LAST_BYTE) begin
            state_next = ST_DONE;
          end else begin
            byte_idx_next = byte_idx_reg + BYTE_W'(1);
            frame_next    = frame_reg << 8;
            state_next    = ST_START;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        // Hold off until upstream drops send so one request sends one frame.
        if (!send) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state so reset forces an idle line immediately.
  always_comb begin
    tx        = 1'b1;
    busy      = 1'b0;
    send_done = 1'b0;
    unique case (state_reg)
      ST_START: begin
        tx   = 1'b0;
        busy = 1'b1;
      end
      ST_DATA: begin
        tx   = cur_byte[bit_idx_reg];
        busy = 1'b1;
      end
      ST_STOP: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        busy      = 1'b1;
        send_done = 1'b1;
      end
      default: begin
        tx = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: two instances (BAUD_DIV 4 and 2)
// compared cycle by cycle against an expected line waveform built from
// the 8N1 framing rules.
module tb_uart_frame_tx;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        send_a, send_b;
  logic [39:0] data_a, data_b;
  logic        done_a, done_b, tx_a, tx_b, busy_a, busy_b;
  logic        sel;
  logic        tx_s, busy_s, done_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_frame_tx #(.FRAME_BITS(40), .BAUD_DIV(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .send(send_a), .data(data_a),
    .send_done(done_a), .tx(tx_a), .busy(busy_a)
  );

  uart_frame_tx #(.FRAME_BITS(40), .BAUD_DIV(2), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .send(send_b), .data(data_b),
    .send_done(done_b), .tx(tx_b), .busy(busy_b)
  );

  assign tx_s   = sel ? tx_b   : tx_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_send(input logic v);
    if (sel) send_b = v; else send_a = v;
  endtask

  task automatic set_data(input logic [39:0] v);
    if (sel) data_b = v; else data_a = v;
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst_b = v; else rst_a = v;
  endtask

  // Sends one frame on the selected instance and checks every cycle.
  // chg_cycle: cycle at which data is overwritten with all ones.
  // pulse_cycle: if >=0, send drops after acceptance and pulses once here.
  // abort_cycle: if >=0, reset is asserted here and the task returns.
  task automatic send_frame(input logic [39:0] frame, input int chg_cycle,
                            input int pulse_cycle, input int abort_cycle,
                            input int keep_high);
    int   bd;
    logic exp_q[$];
    logic [7:0] by;
    bit   aborted;
    bd = sel ? 2 : 4;
    exp_q = {};
    for (int b = 0; b < 5; b++) begin
      by = 8'(frame >> (8 * (4 - b)));
      for (int r = 0; r < bd; r++) exp_q.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int r = 0; r < bd; r++) exp_q.push_back(by[k]);
      for (int r = 0; r < bd; r++) exp_q.push_back(1'b1);
    end

    @(negedge clk);
    set_rst(1'b1);
    set_data(frame);
    set_send(1'b1);
    @(posedge clk);
    aborted = 0;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      check_val("tx_bit", tx_s, exp_q[c]);
      check_val("busy_frame", busy_s, 1'b1);
      check_val("done_early", done_s, 1'b0);
      if (c == chg_cycle) set_data(40'hFFFFFFFFFF);
      if (pulse_cycle >= 0) begin
        if (c == 0) set_send(1'b0);
        if (c == pulse_cycle) set_send(1'b1);
        if (c == pulse_cycle + 1) set_send(1'b0);
      end
      if (c == abort_cycle) begin
        set_rst(1'b0);
        #1;
        check_val("abort_tx", tx_s, 1'b1);
        check_val("abort_busy", busy_s, 1'b0);
        check_val("abort_done", done_s, 1'b0);
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        check_val("rst_hold_tx", tx_s, 1'b1);
        check_val("rst_hold_done", done_s, 1'b0);
      end
      $display("frame %h dut%0d aborted by reset", frame, sel);
      return;
    end
    @(negedge clk);
    check_val("done_pulse", done_s, 1'b1);
    check_val("done_busy", busy_s, 1'b1);
    check_val("done_tx", tx_s, 1'b1);
    @(negedge clk);
    check_val("after_done", done_s, 1'b0);
    check_val("after_busy", busy_s, 1'b0);
    check_val("after_tx", tx_s, 1'b1);
    for (int i = 0; i < keep_high; i++) begin
      @(negedge clk);
      check_val("hold_tx", tx_s, 1'b1);
      check_val("hold_busy", busy_s, 1'b0);
      check_val("hold_done", done_s, 1'b0);
    end
    set_send(1'b0);
    $display("frame %h dut%0d bd=%0d sent", frame, sel, bd);
  endtask

  initial begin
    logic [39:0] rnd;
    sel    = 1'b0;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    send_a = 1'b0;
    send_b = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (3) @(negedge clk);
    check_val("rst_tx_a", tx_a, 1'b1);
    check_val("rst_busy_a", busy_a, 1'b0);
    check_val("rst_done_a", done_a, 1'b0);
    check_val("rst_tx_b", tx_b, 1'b1);
    check_val("rst_busy_b", busy_b, 1'b0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_tx_a", tx_a, 1'b1);
    check_val("idle_busy_a", busy_a, 1'b0);

    // Basic frame, data overwritten at bit-time 7, send held 10 cycles.
    sel = 1'b0;
    send_frame(40'h0000FCF9E7, 28, -1, -1, 10);
    // Re-raise after drop, then abort in byte 2 data bits and restart.
    send_frame(40'h0000FCF9E7, -1, -1, 90, 0);
    send_frame(40'h0000FCF9E7, -1, -1, -1, 2);
    // Stray send pulse during byte 3's stop bit.
    send_frame(40'h123456789A, -1, 39 * 4 + 1, -1, 4);

    // Faster baud instance with edge-bit pattern.
    sel = 1'b1;
    send_frame(40'h8000000001, -1, -1, -1, 3);

    for (int n = 0; n < 6; n++) begin
      sel = n[0];
      rnd = {8'($urandom), $urandom};
      send_frame(rnd, -1, -1, -1, int'($urandom_range(0, 5)));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
